// File: rtl/avlst_64to32_unpack.sv
// Avalon-ST 64->32 unpacker: a small word FIFO feeds a registered output stage
// that emits one or two 32-bit beats per word, remapping empty and tracking packet index.
module avlst_64to32_unpack #(
  parameter int DATA_WIDTH_WR   = 64,
  parameter int DATA_WIDTH_RD   = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter bit DATA_BIG_ENDIAN = 1'b1,
  parameter int INDEX_WIDTH     = 12
) (
  input  logic                     clk_wr,
  input  logic                     rst_n,
  input  logic                     din_restart,
  input  logic                     din_valid,
  input  logic                     din_sop,
  input  logic                     din_eop,
  input  logic [DATA_WIDTH_WR-1:0] din_data,
  input  logic [2:0]               din_empty,
  output logic                     din_ready,
  input  logic                     dout_ready,
  output logic                     dout_valid,
  output logic                     dout_sop,
  output logic                     dout_eop,
  output logic [DATA_WIDTH_RD-1:0] dout_data,
  output logic [1:0]               dout_empty,
  output logic [INDEX_WIDTH-1:0]   dout_index,
  output logic [31:0]              overflow_cnt,
  output logic [31:0]              proto_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DATA_WIDTH_WR + 3 + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} state_t;

  state_t                   state_reg;
  logic [FW-1:0]            mem [FIFO_DEPTH];
  logic [AW:0]              wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic                     fifo_empty, full_next;
  logic                     push, xfer, load;
  logic                     in_pkt_reg;
  logic [DATA_WIDTH_RD-1:0] lo_data_reg;
  logic                     lo_eop_reg;
  logic [1:0]               lo_empty_reg;
  logic [INDEX_WIDTH-1:0]   next_index_reg, idx_inc;

  logic                     h_sop, h_eop, h_single;
  logic [2:0]               h_empty;
  logic [DATA_WIDTH_WR-1:0] h_data;
  logic [DATA_WIDTH_RD-1:0] h_first, h_second;

  assign push       = din_valid & din_ready & ~din_restart;
  assign xfer       = dout_valid & dout_ready;
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  // The output stage owns its word, so the head is popped as soon as it is loaded.
  assign load       = ~fifo_empty & ~din_restart &
                      ((state_reg == IDLE) | (xfer & ((state_reg == LO) | dout_eop)));
  assign idx_inc    = (&dout_index) ? dout_index : dout_index + INDEX_WIDTH'(1);

  always_comb begin
    wr_ptr_next = wr_ptr_reg + (AW+1)'(push);
    rd_ptr_next = rd_ptr_reg + (AW+1)'(load);
    if (din_restart) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  assign full_next = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                     (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

  always_ff @(posedge clk_wr) begin
    if (push)
      mem[wr_ptr_reg[AW-1:0]] <= {din_sop, din_eop, din_empty, din_data};
  end

  assign {h_sop, h_eop, h_empty, h_data} = mem[rd_ptr_reg[AW-1:0]];
  assign h_single = h_eop & h_empty[2];

  generate
    if (DATA_BIG_ENDIAN) begin : g_be
      assign h_first  = h_data[DATA_WIDTH_WR-1 -: DATA_WIDTH_RD];
      assign h_second = h_data[DATA_WIDTH_RD-1:0];
    end else begin : g_le
      assign h_first  = h_data[DATA_WIDTH_RD-1:0];
      assign h_second = h_data[DATA_WIDTH_WR-1 -: DATA_WIDTH_RD];
    end
  endgenerate

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      din_ready     <= 1'b0;
      in_pkt_reg    <= 1'b0;
      overflow_cnt  <= '0;
      proto_err_cnt <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      din_ready  <= ~full_next;
      if (din_valid & ~din_ready)
        overflow_cnt <= overflow_cnt + 32'd1;
      if (push && (din_sop == in_pkt_reg))
        proto_err_cnt <= proto_err_cnt + 32'd1;
      if (din_restart)
        in_pkt_reg <= 1'b0;
      else if (push)
        in_pkt_reg <= din_sop ? ~din_eop : (in_pkt_reg & ~din_eop);
    end
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      dout_valid     <= 1'b0;
      dout_sop       <= 1'b0;
      dout_eop       <= 1'b0;
      dout_data      <= '0;
      dout_empty     <= '0;
      dout_index     <= '0;
      lo_data_reg    <= '0;
      lo_eop_reg     <= 1'b0;
      lo_empty_reg   <= '0;
      next_index_reg <= '0;
    end else if (din_restart) begin
      state_reg      <= IDLE;
      dout_valid     <= 1'b0;
      dout_sop       <= 1'b0;
      dout_eop       <= 1'b0;
      next_index_reg <= '0;
    end else begin
      if (xfer)
        next_index_reg <= idx_inc;
      if (load) begin
        state_reg    <= HI;
        dout_valid   <= 1'b1;
        dout_sop     <= h_sop;
        dout_eop     <= h_single;
        dout_empty   <= h_single ? h_empty[1:0] : 2'd0;
        dout_data    <= h_first;
        lo_data_reg  <= h_second;
        lo_eop_reg   <= h_eop;
        lo_empty_reg <= h_empty[1:0];
        if (h_sop)
          dout_index <= '0;
        else
          dout_index <= xfer ? idx_inc : next_index_reg;
      end else if (xfer) begin
        if (state_reg == HI && !dout_eop) begin
          state_reg  <= LO;
          dout_sop   <= 1'b0;
          dout_eop   <= lo_eop_reg;
          dout_empty <= lo_eop_reg ? lo_empty_reg : 2'd0;
          dout_data  <= lo_data_reg;
          dout_index <= idx_inc;
        end else begin
          state_reg  <= IDLE;
          dout_valid <= 1'b0;
        end
      end
    end
  end

endmodule
